// File: rtl/program_loader.sv
// Instruction-memory loader: assembles a byte stream into instructions,
// writes them to RAM and gates the CPU reset on a good checksum.
module program_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 24
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               load_start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int BYTES = INSTR_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, COUNT, BYTE, WRITE, CHECK, DONE, ERR
  } state_t;

  state_t             state, nxt;
  logic [CNT_W-1:0]   n;
  logic [CNT_W-1:0]   idx;
  logic [BC_W-1:0]    bcnt;
  logic [7:0]         sum;
  logic [INSTR_W-1:0] asm_q;
  logic               xfer;
  logic               last_byte;
  logic               last_word;
  logic [7:0]         chk_sum;

  assign xfer      = rx_valid & rx_ready;
  assign last_byte = (bcnt == BC_W'(BYTES - 1));
  assign last_word = (idx == n - CNT_W'(1));
  assign chk_sum   = sum + rx_data;

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR:
        if (load_start) nxt = COUNT;
      COUNT:
        if (xfer) nxt = BYTE;
      BYTE:
        if (xfer && last_byte) nxt = WRITE;
      WRITE:
        nxt = last_word ? CHECK : BYTE;
      CHECK:
        if (xfer) nxt = (chk_sum == 8'h00) ? DONE : ERR;
      default:
        nxt = IDLE;
    endcase
  end

  // A count byte of zero stands for a full memory of 2**ADDR_W words.
  always_ff @(posedge CLK) begin
    if (reset) begin
      n     <= '0;
      idx   <= '0;
      bcnt  <= '0;
      sum   <= '0;
      asm_q <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (load_start) begin
            n     <= '0;
            idx   <= '0;
            bcnt  <= '0;
            sum   <= '0;
            asm_q <= '0;
          end
        end
        COUNT: begin
          if (xfer) begin
            n   <= (rx_data == 8'h00) ? CNT_W'(1 << ADDR_W)
                                      : CNT_W'(rx_data);
            sum <= sum + rx_data;
          end
        end
        BYTE: begin
          if (xfer) begin
            asm_q <= (asm_q << 8) | INSTR_W'(rx_data);
            sum   <= sum + rx_data;
            bcnt  <= last_byte ? '0 : bcnt + BC_W'(1);
          end
        end
        WRITE:
          idx <= idx + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign rx_ready  = (state == COUNT) || (state == BYTE) ||
                     (state == CHECK);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = idx[ADDR_W-1:0];
  assign mem_wdata = asm_q;
  assign busy      = (state == COUNT) || (state == BYTE) ||
                     (state == WRITE) || (state == CHECK);
  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign cpu_reset = (state != DONE);

endmodule
